// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add multiply and restoring divide (one step per cycle, WIDTH steps).
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
  logic [WIDTH-1:0] acc_q, acc_d;
  // opa: shifting multiplicand (MUL) or dividend/quotient shift register (DIV)
  logic [WIDTH-1:0] opa_q, opa_d;
  // opb: shifting multiplier (MUL) or fixed divisor (DIV)
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             is_iter;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] rem_new;
  logic [WIDTH-1:0] q_new;
  logic [WIDTH-1:0] iter_res;

  assign shamt   = b[SHW-1:0];
  assign is_iter = (aluOp >= 4'd10) && (aluOp <= 4'd12);

  // Single-cycle operation results, evaluated on the live inputs at accept.
  always_comb begin
    alu_res = '0;
    case (aluOp)
      4'd0:    alu_res = a + b;
      4'd1:    alu_res = a - b;
      4'd2:    alu_res = a & b;
      4'd3:    alu_res = a | b;
      4'd4:    alu_res = a ^ b;
      4'd5:    alu_res = a << shamt;
      4'd6:    alu_res = a >> shamt;
      4'd7:    alu_res = WIDTH'($signed(a) >>> shamt);
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // One multiply or restoring-divide step from the current working registers.
  always_comb begin
    mul_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
    rem_sh  = {acc_q, opa_q[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, opb_q});
    // When div_ge holds the difference fits in WIDTH bits, so low bits suffice.
    div_sub = rem_sh[WIDTH-1:0] - opb_q;
    rem_new = div_ge ? div_sub : rem_sh[WIDTH-1:0];
    q_new   = {opa_q[WIDTH-2:0], div_ge};
    case (op_q)
      4'd10:   iter_res = mul_acc;
      4'd11:   iter_res = q_new;
      default: iter_res = rem_new;
    endcase
  end

  // Next-state logic: accept in idle, step while iterating, single done cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d = aluOp;
          if (is_iter) begin
            state_d = StIter;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            opa_d   = a;
            opb_d   = b;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      StIter: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == 4'd10) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = rem_new;
          opa_d = q_new;
        end
        if (cnt_q == CW'(1)) begin
          state_d  = StDone;
          result_d = iter_res;
          zero_d   = (iter_res == '0);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases plus
// random operations compared with an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .aluOp  (op),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the operation table.
  function automatic logic [31:0] model(input logic [3:0] xop, input logic [31:0] x,
                                        input logic [31:0] y);
    int unsigned sh;
    sh = y % 32;
    case (xop)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return x << sh;
      4'd6:    return x >> sh;
      4'd7:    return $unsigned($signed(x) >>> sh);
      4'd8:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:    return (x < y) ? 32'd1 : 32'd0;
      4'd10:   return x * y;
      4'd11:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd12:   return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] xop);
    return (xop >= 4'd10 && xop <= 4'd12) ? 33 : 1;
  endfunction

  // Issue one op at a negedge, scramble operands afterwards, wait for done.
  task automatic run_op(input logic [3:0] xop, input logic [31:0] xa, input logic [31:0] xb,
                        output logic [31:0] res, output logic zr, output int lat,
                        output bit busy_ok, output bit stable_ok);
    logic [31:0] prev;
    @(negedge clk);
    check("idle_before_start", {30'd0, busy, done}, 32'd0);
    prev  = result;
    start = 1'b1;
    op    = xop;
    a     = xa;
    b     = xb;
    @(negedge clk);
    start     = 1'b0;
    a         = $urandom;
    b         = $urandom;
    op        = 4'($urandom);
    lat       = 1;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (!done && lat < 100) begin
      busy_ok   &= (busy === 1'b1);
      stable_ok &= (result === prev);
      @(negedge clk);
      lat++;
    end
    busy_ok &= (busy === 1'b1);
    res = result;
    zr  = zero;
  endtask

  task automatic do_op(input string tag, input logic [3:0] xop, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [31:0] exp);
    logic [31:0] res;
    logic        zr;
    int          lat;
    bit          busy_ok;
    bit          stable_ok;
    run_op(xop, xa, xb, res, zr, lat, busy_ok, stable_ok);
    check($sformatf("%s.result", tag), res, exp);
    check($sformatf("%s.zero", tag), 32'(zr), (exp == 0) ? 32'd1 : 32'd0);
    check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat(xop)));
    check($sformatf("%s.busy", tag), 32'(busy_ok), 32'd1);
    check($sformatf("%s.stable", tag), 32'(stable_ok), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    logic [31:0] mres;
    int          ndone;
    int          first;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Wrap-around, subtraction, shifts and compares.
    do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    do_op("sub_neg", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    do_op("sra", 4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
    do_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
    do_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    do_op("op15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

    // Iterative multiply and divide, including divide by zero.
    do_op("mul", 4'd10, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000);
    do_op("divu", 4'd11, 32'd100, 32'd7, 32'd14);
    do_op("remu", 4'd12, 32'd100, 32'd7, 32'd2);
    do_op("divu_zero", 4'd11, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
    do_op("remu_zero", 4'd12, 32'd9, 32'd0, 32'd9);

    // Start during a MUL must be ignored; operands change after acceptance.
    @(negedge clk);
    start = 1'b1;
    op    = 4'd10;
    a     = 32'h0001_2345;
    b     = 32'h0001_0000;
    ndone = 0;
    first = 0;
    mres  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = k;
          mres  = result;
        end
      end
      start = (k == 5);
      op    = 4'd0;
      a     = 32'hFFFF_FFFF;
      b     = 32'hFFFF_FFFF;
    end
    start = 1'b0;
    check("busy_start.ndone", 32'(ndone), 32'd1);
    check("busy_start.latency", 32'(first), 32'd33);
    check("busy_start.result", mres, 32'h2345_0000);

    // Reset ten cycles into a DIVU aborts it; start during reset is ignored.
    @(negedge clk);
    start = 1'b1;
    op    = 4'd11;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    op    = 4'd0;
    a     = 32'd2;
    b     = 32'd3;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.result", result, 32'd0);
    check("abort.zero", 32'(zero), 32'd1);
    @(negedge clk);
    check("abort.start_in_reset", 32'(busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    do_op("after_reset_add", 4'd0, 32'd2, 32'd3, 32'd5);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL derive SHW = log2(WIDTH) internally as the shift-amount width; it is not a port-level parameter.
REQ-003 SHALL have ports, in this order:
- clk, input, 1, sole clock; rising edge.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, operation request.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- aluOp, input, 4, operation select.
- busy, output, 1, operation in flight; start is ignored while high.
- done, output, 1, one-cycle pulse; result is valid.
- result, output, WIDTH, registered result.
- zero, output, 1, registered (result == 0).

Function
REQ-004 SHALL decode aluOp as:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLL, 6 SRL, 7 SRA; shift amount is b[SHW-1:0].
- 8 SLT (signed), 9 SLTU; result is 1 or 0.
- 10 MUL (low WIDTH bits), 11 DIVU, 12 REMU.
- 13-15 give result 0.
REQ-005 SHALL wrap ADD, SUB and MUL modulo 2^WIDTH, with no overflow flag.
REQ-006 SHALL implement the FSM states IDLE, ITER and DONE; busy = (state != IDLE).
REQ-007 SHALL accept start only in IDLE, capturing a, b and aluOp on that edge; later operand changes have no effect.
REQ-008 SHALL handle single-cycle ops (0-9, 13-15) as IDLE -> DONE, with result written on the accepting edge; done is high in the cycle after start (latency 1).
REQ-009 SHALL handle iterative ops (10-12) as IDLE -> ITER, with the counter loaded to WIDTH and one shift-add or restoring-divide step per ITER cycle; ITER -> DONE when the counter reaches 0, so done is high WIDTH+1 cycles after the start edge.
REQ-010 SHALL assert done only in DONE, for exactly one cycle; DONE -> IDLE unconditionally, so minimum issue spacing is 2 cycles (single-cycle ops) or WIDTH+2 cycles (iterative ops).
REQ-011 SHALL hold result and zero stable from done until the next done; they do not change during ITER.
REQ-012 SHALL, when start is asserted while busy, ignore it without corrupting the in-flight operation.
REQ-013 SHALL handle divide by zero as: DIVU result all-ones, REMU result = a; latency is unchanged at WIDTH+1.
REQ-014 SHALL update zero in the same edge as result.

Reset
REQ-015 SHALL, while reset is high, immediately (asynchronously) force state = IDLE, busy = 0, done = 0, result = 0, zero = 1 and counter = 0.
REQ-016 SHALL, on reset asserted mid-ITER, abort the operation with no done pulse; the first start after reset deassertion is accepted normally.
REQ-017 SHALL ignore start in any cycle in which reset is high.

Verification
REQ-018 SHALL cover: WIDTH=32, ADD a=0xFFFFFFFF, b=1 -> done at T+1, result 0x00000000, zero 1; then SUB a=5, b=7 -> 0xFFFFFFFE, zero 0.
REQ-019 SHALL cover: SRA a=0x80000000, b=0x24 -> 0xF8000000 (shift 4, upper b bits ignored); SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-020 SHALL cover: MUL a=0x00012345, b=0x00010000 -> done exactly at T+33, result 0x23450000; busy high T+1..T+33.
REQ-021 SHALL cover: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each with done at T+33.
REQ-022 SHALL cover: start with ADD issued at T+5 during a MUL -> ignored; a single done at T+33 carrying the MUL result; operands changed after T have no effect.
REQ-023 SHALL cover: reset pulsed at T+10 of a DIVU -> busy 0, result 0, zero 1 immediately, no done; a subsequent ADD 2+3 -> 5 at latency 1.
